hdr_tone_map: RTL and testbench

//  Display-side consumer of the HDR merge output. Takes per-channel log-radiance (Q4.4, 8 bit)
//  and maps it to RGB565 for the frame-buffer writer. Global per-frame normalisation: min/max
//  of frame k set offset/scale for frame k+1. Absorbs downstream backpressure with an input FIFO,

---
 rtl/hdr_tone_map.sv | 197 +++++++++++++++++++
 tb/tb_hdr_tone_map.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hdr_tone_map.sv
// Log-radiance (Q4.4) to RGB565 tone mapper with per-frame min/scale normalisation.
// Statistics gathered over frame k program the offset and scale applied to frame k+1.
module hdr_tone_map #(
    parameter int unsigned N          = 8,
    parameter int unsigned FP         = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SCALE_W    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] lE_red,
    input  logic [N-1:0] lE_green,
    input  logic [N-1:0] lE_blue,
    input  logic         in_valid,
    input  logic         frame_end,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [15:0]  pixel_out,
    output logic         busy,
    output logic         overflow
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(SCALE_W);
    localparam int unsigned PW = N + SCALE_W;
    localparam int unsigned SF = 8;
    localparam logic [AW:0]        Full     = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]        CntOne   = (AW + 1)'(1);
    localparam logic [AW-1:0]      PtrOne   = AW'(1);
    localparam logic [SCALE_W-1:0] Dividend = SCALE_W'(255 << SF);
    localparam logic [SCALE_W-1:0] Identity = SCALE_W'(1 << SF);
    localparam logic [CW-1:0]      LastStep = CW'(SCALE_W - 1);

    if (FP >= N) begin : g_bad_fp
        $error("FP must be smaller than N");
    end

    typedef enum logic [1:0] {StIdle, StDiv, StUpdate} state_e;

    logic [3*N-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q;
    logic           advance, pop, push, drop;
    logic [N-1:0]   head [3];
    logic [N-1:0]   in_ch [3];

    logic           s1_valid_q, s2_valid_q;
    logic [N-1:0]   s1_d_q [3];
    logic [SCALE_W-1:0] s1_scale_q;
    logic [15:0]    s2_pix_q;
    logic [N-1:0]   d_c [3];
    logic [PW-1:0]  prod_c [3];
    logic [N-1:0]   p_c [3];
    logic [15:0]    pix_c;

    state_e         state_q;
    logic [N-1:0]   cur_min_q, cur_max_q, frame_min_c, frame_max_c;
    logic [N-1:0]   smin_q, range_q, rem_q, rem_nx, min_q;
    logic [N:0]     rem_sh;
    logic           ge, start;
    logic [SCALE_W-1:0] dvd_q, quo_q, scale_q;
    logic [CW-1:0]  cnt_q;

    assign in_ch   = '{lE_red, lE_green, lE_blue};
    assign head[0] = fifo_mem[rd_ptr_q][3*N-1:2*N];
    assign head[1] = fifo_mem[rd_ptr_q][2*N-1:N];
    assign head[2] = fifo_mem[rd_ptr_q][N-1:0];

    // The whole pipeline freezes only when a valid output is refused.
    assign advance = !(out_valid && !out_ready);
    assign pop     = advance && (count_q != '0);
    assign push    = in_valid && (count_q != Full);
    assign drop    = in_valid && (count_q == Full);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {lE_red, lE_green, lE_blue};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            if (push && !pop)      count_q <= count_q + CntOne;
            else if (pop && !push) count_q <= count_q - CntOne;
            if (drop)           overflow <= 1'b1;
            else if (frame_end) overflow <= 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            d_c[i]    = (head[i] > min_q) ? head[i] - min_q : '0;
            prod_c[i] = (PW'(s1_d_q[i]) * PW'(s1_scale_q)) >> SF;
            p_c[i]    = (|prod_c[i][PW-1:N]) ? '1 : prod_c[i][N-1:0];
        end
        pix_c = {5'(p_c[0] >> (N - 5)), 6'(p_c[1] >> (N - 6)), 5'(p_c[2] >> (N - 5))};
    end

    // Scale travels with the pixel so an UPDATE between S1 and S2 cannot mix params.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            out_valid  <= 1'b0;
            pixel_out  <= '0;
        end else if (advance) begin
            s1_valid_q <= pop;
            s2_valid_q <= s1_valid_q;
            out_valid  <= s2_valid_q;
            if (pop) begin
                s1_d_q     <= d_c;
                s1_scale_q <= scale_q;
            end
            if (s1_valid_q) s2_pix_q  <= pix_c;
            if (s2_valid_q) pixel_out <= s2_pix_q;
        end
    end

    always_comb begin
        frame_min_c = cur_min_q;
        frame_max_c = cur_max_q;
        if (in_valid) begin
            for (int i = 0; i < 3; i++) begin
                if (in_ch[i] < frame_min_c) frame_min_c = in_ch[i];
                if (in_ch[i] > frame_max_c) frame_max_c = in_ch[i];
            end
        end
    end

    assign start  = frame_end && (frame_max_c >= frame_min_c);
    assign rem_sh = {rem_q, dvd_q[SCALE_W-1]};
    assign ge     = rem_sh >= {1'b0, range_q};
    assign rem_nx = ge ? N'(rem_sh - {1'b0, range_q}) : rem_sh[N-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_min_q <= '1;
            cur_max_q <= '0;
        end else if (frame_end) begin
            cur_min_q <= '1;
            cur_max_q <= '0;
        end else begin
            cur_min_q <= frame_min_c;
            cur_max_q <= frame_max_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            min_q   <= '0;
            scale_q <= Identity;
            smin_q  <= '0;
            range_q <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StDiv: begin
                    rem_q <= rem_nx;
                    dvd_q <= dvd_q << 1;
                    quo_q <= {quo_q[SCALE_W-2:0], ge};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LastStep) begin
                        state_q <= StUpdate;
                        busy    <= 1'b0;
                    end
                end
                StUpdate: begin
                    min_q   <= smin_q;
                    scale_q <= (range_q == '0) ? '0 : quo_q;
                    state_q <= StIdle;
                end
                default: ;
            endcase
            // A new frame (re)starts the divide from any state; later NBAs win.
            if (start) begin
                smin_q  <= frame_min_c;
                range_q <= frame_max_c - frame_min_c;
                rem_q   <= '0;
                dvd_q   <= Dividend;
                quo_q   <= '0;
                cnt_q   <= '0;
                busy    <= 1'b1;
                state_q <= StDiv;
            end
        end
    end

endmodule

// File: tb/tb_hdr_tone_map.sv
// Scoreboard bench for hdr_tone_map: directed stimulus pushes expected pixels,
// a negedge monitor pops and compares on every accepted output.
module tb_hdr_tone_map;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  lE_red = '0, lE_green = '0, lE_blue = '0;
    logic        in_valid = 1'b0, frame_end = 1'b0, out_ready = 1'b1;
    logic        out_valid, busy, overflow;
    logic [15:0] pixel_out;

    always #5 clk = ~clk;

    hdr_tone_map #(.N(8), .FP(4), .FIFO_DEPTH(4), .SCALE_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .lE_red(lE_red), .lE_green(lE_green), .lE_blue(lE_blue),
        .in_valid(in_valid), .frame_end(frame_end), .out_ready(out_ready),
        .out_valid(out_valid), .pixel_out(pixel_out), .busy(busy), .overflow(overflow)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    string       phase = "reset";
    logic [15:0] exp_q [$];
    int          model_min, model_scale, st_min, st_max, pend_min, pend_scale, n;
    bit          pending;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s/%s: got 0x%0h, required 0x%0h", phase, name, act, req);
    endtask

    function automatic logic [15:0] model_pix(input int r, input int g, input int b);
        int ch[3];
        int p[3];
        ch = '{r, g, b};
        for (int i = 0; i < 3; i++) begin
            int d;
            d = (ch[i] > model_min) ? ch[i] - model_min : 0;
            p[i] = (d * model_scale) >> 8;
            if (p[i] > 255) p[i] = 255;
        end
        return {5'(p[0] >> 3), 6'(p[1] >> 2), 5'(p[2] >> 3)};
    endfunction

    // Monitor: compare accepted outputs, and check held values across stall cycles.
    logic [15:0] held;
    bit          stalled = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_pixel", int'(pixel_out), int'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL %s/spurious: got 0x%0h, required no output", phase, pixel_out);
                end else begin
                    check("pixel", int'(pixel_out), int'(exp_q.pop_front()));
                end
            end
            stalled = out_valid && !out_ready;
            held    = pixel_out;
        end
    end

    task automatic model_reset();
        model_min = 0; model_scale = 256; st_min = 255; st_max = 0; pending = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_pixel_out", int'(pixel_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overflow", int'(overflow), 0);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic send(input int r, input int g, input int b, input logic [15:0] exp,
                        input bit accept);
        int ch[3];
        ch = '{r, g, b};
        lE_red = 8'(r); lE_green = 8'(g); lE_blue = 8'(b);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (ch[i] < st_min) st_min = ch[i];
            if (ch[i] > st_max) st_max = ch[i];
        end
        if (accept) exp_q.push_back(exp);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic frame_end_pulse();
        frame_end = 1'b1;
        if (st_max >= st_min) begin
            pend_min   = st_min;
            pend_scale = (st_max == st_min) ? 0 : 65280 / (st_max - st_min);
            pending    = 1'b1;
        end
        st_min = 255; st_max = 0;
        @(posedge clk);
        #1 frame_end = 1'b0;
    endtask

    task automatic wait_div(output int cycles);
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) cycles++;
            else break;
        end
        repeat (2) @(posedge clk);
        #1;
        if (pending) begin
            model_min = pend_min; model_scale = pend_scale; pending = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        do_reset();

        phase = "T1";
        send('h40, 'h80, 'hFF, 16'h441F, 1'b1);
        repeat (2) @(posedge clk);
        #1 check("latency_3", int'(out_valid), 0);
        @(posedge clk);
        #1 check("latency_4", int'(out_valid), 1);
        drain();
        do_reset();

        phase = "T2";
        send('h20, 'h40, 'h60, model_pix('h20, 'h40, 'h60), 1'b1);
        send('h30, 'h50, 'h58, model_pix('h30, 'h50, 'h58), 1'b1);
        drain();
        frame_end_pulse();
        wait_div(n);
        check("busy_cycles", n, 16);
        send('h60, 'h40, 'h20, 16'hFBE0, 1'b1);
        phase = "T3";
        send('h10, 'hA0, 'h20, 16'h07E0, 1'b1);
        drain();

        phase = "T4";
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            send('h28 + i * 'h10, 'hB0 - i * 'h10, 'h30 + i * 4,
                 model_pix('h28 + i * 'h10, 'hB0 - i * 'h10, 'h30 + i * 4), i < 7);
        check("overflow_set", int'(overflow), 1);
        idle(4);
        out_ready = 1'b1;
        drain();
        check("overflow_sticky", int'(overflow), 1);

        phase = "T5";
        frame_end_pulse();
        check("overflow_clr", int'(overflow), 0);
        wait_div(n);
        check("busy_cycles", n, 16);
        frame_end_pulse();
        wait_div(n);
        check("empty_frame_busy", n, 0);
        send('h70, 'h50, 'h90, model_pix('h70, 'h50, 'h90), 1'b1);
        drain();
        send('h10, 'h50, 'h90, model_pix('h10, 'h50, 'h90), 1'b1);
        idle(4);
        frame_end_pulse();
        idle(3);
        check("busy_mid_div", int'(busy), 1);
        send('h30, 'h40, 'h50, model_pix('h30, 'h40, 'h50), 1'b1);
        frame_end_pulse();
        wait_div(n);
        check("restart_busy", n, 16);
        send('h50, 'h38, 'h30, 16'hF9E0, 1'b1);
        drain();

        phase = "T6";
        send('h08, 'h70, 'h30, model_pix('h08, 'h70, 'h30), 1'b1);
        drain();
        frame_end_pulse();
        idle(5);
        do_reset();
        idle(25);
        check("busy_after_rst", int'(busy), 0);
        send('h40, 'h80, 'hFF, 16'h441F, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
